// File: rtl/mem_ctrl_pkg.sv
// Shared defaults and FSM encoding for the bit-cell memory access controller.
package mem_ctrl_pkg;

    localparam int unsigned MEM_ADDR_W = 4;
    localparam int unsigned MEM_DATA_W = 8;
    localparam int unsigned MEM_WORDS  = 1 << MEM_ADDR_W;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_WRITE      = 3'd1;
    localparam logic [STATE_W-1:0] ST_RD_ISSUE   = 3'd2;
    localparam logic [STATE_W-1:0] ST_RD_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESP       = 3'd4;

endpackage

// File: rtl/mem_addr_decoder.sv
// Binary word address to one-hot word select, gated by an enable.
module mem_addr_decoder
    import mem_ctrl_pkg::*;
#(
    parameter  int unsigned ADDR_W = MEM_ADDR_W,
    localparam int unsigned WORDS  = 1 << ADDR_W
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORDS-1:0]  sel
);

    // At most one select line, and none when disabled
    always_comb begin
        sel = '0;
        if (en) begin
            sel[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response front end that sequences one-cycle write and read
// strobes into a bit-cell array whose read data lags the select by a cycle.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int unsigned ADDR_W = MEM_ADDR_W,
    parameter  int unsigned DATA_W = MEM_DATA_W,
    localparam int unsigned WORDS  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [WORDS-1:0]  mem_sel,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic               accept_c;

    logic               cmd_we;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;

    logic               wr_phase_c;
    logic               rd_phase_c;

    // State register; reset forces IDLE, which immediately drops the strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and acceptance decode
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                accept_c = req_valid & req_ready;
                if (accept_c) begin
                    state_next = req_we ? ST_WRITE : ST_RD_ISSUE;
                end
            end
            ST_WRITE:      state_next = ST_IDLE;
            ST_RD_ISSUE:   state_next = ST_RD_CAPTURE;
            ST_RD_CAPTURE: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default:       state_next = ST_IDLE;
        endcase
    end

    // Command fields are latched only on acceptance, so traffic while busy is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept_c) begin
            cmd_we    <= req_we;
            cmd_addr  <= req_addr;
            cmd_wdata <= req_wdata;
        end
    end

    // Handshake and status flags follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (state_next == ST_IDLE);
            busy      <= (state_next != ST_IDLE);
            rsp_valid <= (state_next == ST_RESP);
        end
    end

    // Cell array output is valid during RD_CAPTURE and held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
        end else if (state == ST_RD_CAPTURE) begin
            rsp_rdata <= mem_dout;
        end
    end

    // Strobe phases decoded from flops only, so no input reaches the array combinationally
    assign wr_phase_c = (state == ST_WRITE)    &  cmd_we;
    assign rd_phase_c = (state == ST_RD_ISSUE) & ~cmd_we;

    assign mem_rw  = ~wr_phase_c;
    assign mem_din = wr_phase_c ? cmd_wdata : '0;

    mem_addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_addr_decoder (
        .en   (wr_phase_c | rd_phase_c),
        .addr (cmd_addr),
        .sel  (mem_sel)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 16x8 bit-cell array model.
module tb_mem_access_ctrl;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [3:0]  req_addr  = 4'h0;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_ready = 1'b0;

    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] mem_sel;
    logic        mem_rw;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_sel   (mem_sel),
        .mem_rw    (mem_rw),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .busy      (busy)
    );

    // Cell array: writes on select with rw=0; each cell registers rw&sel&bit, outputs ORed
    logic [7:0] cells [16] = '{default: 8'h00};
    logic [7:0] cell_rd;
    logic [7:0] cell_dout = 8'h00;

    always_comb begin
        cell_rd = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (mem_rw && mem_sel[i]) cell_rd = cell_rd | cells[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (!mem_rw && mem_sel[i]) cells[i] <= mem_din;
        end
        cell_dout <= cell_rd;
    end

    assign mem_dout = cell_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("sel_onehot", 32'($countones(mem_sel) <= 1), 32'd1);
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] d,
                            input logic [15:0] exp_sel);
        check({tag, "_ready0"}, 32'(req_ready), 32'd1);
        drive(1'b1, 1'b1, a, d);
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00);
        check({tag, "_sel"},    32'(mem_sel),   32'(exp_sel));
        check({tag, "_rw"},     32'(mem_rw),    32'd0);
        check({tag, "_din"},    32'(mem_din),   32'(d));
        check({tag, "_ready1"}, 32'(req_ready), 32'd0);
        check({tag, "_busy1"},  32'(busy),      32'd1);
        step();
        check({tag, "_sel_off"}, 32'(mem_sel),   32'd0);
        check({tag, "_rw_off"},  32'(mem_rw),    32'd1);
        check({tag, "_din_off"}, 32'(mem_din),   32'd0);
        check({tag, "_ready2"},  32'(req_ready), 32'd1);
        check({tag, "_busy2"},   32'(busy),      32'd0);
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [15:0] exp_sel,
                           input logic [7:0] exp_data);
        check({tag, "_ready0"}, 32'(req_ready), 32'd1);
        drive(1'b1, 1'b0, a, 8'h00);
        rsp_ready = 1'b1;
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00);
        check({tag, "_sel"},    32'(mem_sel),   32'(exp_sel));
        check({tag, "_rw"},     32'(mem_rw),    32'd1);
        check({tag, "_valid1"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready1"}, 32'(req_ready), 32'd0);
        step();
        check({tag, "_sel_cap"}, 32'(mem_sel),   32'd0);
        check({tag, "_valid2"},  32'(rsp_valid), 32'd0);
        step();
        check({tag, "_valid3"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rdata"},  32'(rsp_rdata), 32'(exp_data));
        step();
        check({tag, "_valid4"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready4"}, 32'(req_ready), 32'd1);
        check({tag, "_busy4"},  32'(busy),      32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset values while rst_n is low
        #1;
        check("rst_sel",   32'(mem_sel),   32'd0);
        check("rst_rw",    32'(mem_rw),    32'd1);
        check("rst_din",   32'(mem_din),   32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", 32'(req_ready), 32'd1);

        // Basic write then read-back at address 3
        do_write("w3", 4'd3, 8'hA5, 16'h0008);
        do_read("r3", 4'd3, 16'h0008, 8'hA5);

        // Address extremes and an unwritten word
        do_write("w0",  4'd0,  8'h01, 16'h0001);
        do_write("w15", 4'd15, 8'h80, 16'h8000);
        do_read("r0",  4'd0,  16'h0001, 8'h01);
        do_read("r15", 4'd15, 16'h8000, 8'h80);
        do_read("r7",  4'd7,  16'h0080, 8'h00);

        // Response held off for 5 cycles
        drive(1'b1, 1'b0, 4'd15, 8'h00);
        rsp_ready = 1'b0;
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", 32'(rsp_rdata), 32'h80);
            check("hold_ready", 32'(req_ready), 32'd0);
            if (k < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("hold_release_valid", 32'(rsp_valid), 32'd0);
        check("hold_release_ready", 32'(req_ready), 32'd1);

        // Reset asserted during RD_ISSUE
        do_write("w5", 4'd5, 8'h3C, 16'h0020);
        drive(1'b1, 1'b0, 4'd5, 8'h00);
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00);
        check("rdrst_sel_before", 32'(mem_sel), 32'h0020);
        #1;
        rst_n = 1'b0;
        #1;
        check("rdrst_sel",   32'(mem_sel),   32'd0);
        check("rdrst_rw",    32'(mem_rw),    32'd1);
        check("rdrst_busy",  32'(busy),      32'd0);
        check("rdrst_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rdrst_no_rsp", 32'(rsp_valid), 32'd0);
            check("rdrst_idle",   32'(busy),      32'd0);
        end
        do_read("r5", 4'd5, 16'h0020, 8'h3C);

        // Reset asserted during RESP discards the data
        drive(1'b1, 1'b0, 4'd0, 8'h00);
        rsp_ready = 1'b0;
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00);
        step();
        step();
        check("resprst_valid_pre", 32'(rsp_valid), 32'd1);
        check("resprst_rdata_pre", 32'(rsp_rdata), 32'h01);
        rst_n = 1'b0;
        #1;
        check("resprst_valid", 32'(rsp_valid), 32'd0);
        check("resprst_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("resprst_valid_post", 32'(rsp_valid), 32'd0);
        check("resprst_ready_post", 32'(req_ready), 32'd1);

        // Held req_valid with changing commands; busy cycles must not accept
        drive(1'b1, 1'b1, 4'd9, 8'h5A);
        step();
        check("b2b_w9_sel", 32'(mem_sel), 32'h0200);
        check("b2b_w9_din", 32'(mem_din), 32'h5A);
        drive(1'b1, 1'b1, 4'd2, 8'hFF);
        step();
        check("b2b_idle_ready", 32'(req_ready), 32'd1);
        check("b2b_idle_rw",    32'(mem_rw),    32'd1);
        check("b2b_idle_din",   32'(mem_din),   32'd0);
        drive(1'b1, 1'b0, 4'd9, 8'h00);
        rsp_ready = 1'b1;
        step();
        check("b2b_r9_sel", 32'(mem_sel), 32'h0200);
        check("b2b_r9_rw",  32'(mem_rw),  32'd1);
        drive(1'b1, 1'b1, 4'd2, 8'hFF);
        step();
        check("b2b_cap_sel", 32'(mem_sel), 32'd0);
        check("b2b_cap_rw",  32'(mem_rw),  32'd1);
        step();
        check("b2b_r9_valid", 32'(rsp_valid), 32'd1);
        check("b2b_r9_rdata", 32'(rsp_rdata), 32'h5A);
        drive(1'b1, 1'b1, 4'd10, 8'h77);
        step();
        check("b2b_idle2_ready", 32'(req_ready), 32'd1);
        check("b2b_idle2_valid", 32'(rsp_valid), 32'd0);
        check("b2b_idle2_rw",    32'(mem_rw),    32'd1);
        step();
        drive(1'b0, 1'b0, 4'h0, 8'h00);
        rsp_ready = 1'b0;
        check("b2b_w10_sel", 32'(mem_sel), 32'h0400);
        check("b2b_w10_rw",  32'(mem_rw),  32'd0);
        check("b2b_w10_din", 32'(mem_din), 32'h77);
        step();
        check("b2b_w10_done", 32'(req_ready), 32'd1);

        do_read("r9",  4'd9,  16'h0200, 8'h5A);
        do_read("r10", 4'd10, 16'h0400, 8'h77);
        do_read("r2",  4'd2,  16'h0004, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
